// File: rtl/reg_file_param_if.sv
// Register-file access bus: decode-side reads and busy marking, writeback-side writes.
// The register file takes the slave view; the driving pipeline (or bench) takes master.
interface reg_file_param_if #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    parameter int NREAD = 2
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                  reg_wr;
    logic [AW-1:0]         Rd;
    logic [W-1:0]          DI;
    logic                  reg_rd;
    logic [NREAD*AW-1:0]   Rs;
    logic [NREAD*W-1:0]    D;
    logic                  rd_valid;
    logic [NREAD-1:0]      hazard;
    logic                  bsy_set;
    logic [AW-1:0]         bsy_Rd;
    logic [DEPTH-1:0]      busy;

    modport master (
        output reg_wr, Rd, DI, reg_rd, Rs, bsy_set, bsy_Rd,
        input  D, rd_valid, hazard, busy
    );

    modport slave (
        input  reg_wr, Rd, DI, reg_rd, Rs, bsy_set, bsy_Rd,
        output D, rd_valid, hazard, busy
    );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised register file: NREAD registered read ports with write-first bypass,
// plus a per-register busy scoreboard (set at issue, cleared at writeback).
// Optional macro ZERO_REG_EN: register 0 reads as zero, ignores writes, never busy.
module reg_file_param #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    parameter int NREAD = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    reg_file_param_if.slave  bus
);
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
`ifdef ZERO_REG_EN
    localparam logic        ZR      = 1'b1;
`else
    localparam logic        ZR      = 1'b0;
`endif

    // Addresses can exceed DEPTH when DEPTH is not a power of two.
    function automatic logic in_rng(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_C;
    endfunction

    function automatic logic is_r0(input logic [AW-1:0] a);
        return ZR && (a == '0);
    endfunction

    logic [W-1:0]              mem_q [DEPTH];
    logic [DEPTH-1:0]          busy_q, busy_d;
    logic [NREAD-1:0][W-1:0]   d_q, d_d;
    logic [NREAD-1:0]          haz_q, haz_d;
    logic                      vld_q;
    logic                      wr_ok;

    assign wr_ok = bus.reg_wr && in_rng(bus.Rd) && !is_r0(bus.Rd);

    // Per-port read value and hazard; a same-cycle write to the source forwards DI
    // and also resolves the hazard since the producer has completed.
    always_comb begin
        d_d   = '0;
        haz_d = '0;
        for (int i = 0; i < NREAD; i++) begin
            logic [AW-1:0] a;
            logic          hit;
            a   = bus.Rs[i*AW +: AW];
            hit = bus.reg_wr && (bus.Rd == a);
            if (bus.reg_rd && in_rng(a) && !is_r0(a)) begin
                d_d[i]   = hit ? bus.DI : mem_q[a];
                haz_d[i] = busy_q[a] && !hit;
            end
        end
    end

    // Scoreboard next state: clear on writeback first, so a same-cycle issue wins.
    always_comb begin
        busy_d = busy_q;
        if (bus.reg_wr && in_rng(bus.Rd))
            busy_d[bus.Rd] = 1'b0;
        if (bus.bsy_set && in_rng(bus.bsy_Rd) && !is_r0(bus.bsy_Rd))
            busy_d[bus.bsy_Rd] = 1'b1;
    end

    // Register array write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++)
                mem_q[r] <= '0;
        end else if (wr_ok) begin
            mem_q[bus.Rd] <= bus.DI;
        end
    end

    // Read-side output registers and scoreboard state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q    <= '0;
            haz_q  <= '0;
            vld_q  <= 1'b0;
            busy_q <= '0;
        end else begin
            d_q    <= d_d;
            haz_q  <= haz_d;
            vld_q  <= bus.reg_rd;
            busy_q <= busy_d;
        end
    end

    assign bus.D        = d_q;
    assign bus.hazard   = haz_q;
    assign bus.rd_valid = vld_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: directed scenarios plus randomized traffic checked
// against an array-based reference model. Honors ZERO_REG_EN when defined.
module tb_reg_file_param;
    localparam int W = 32, DEPTH = 16, NREAD = 2, AW = 4;
`ifdef ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    reg_file_param_if #(.W(W), .DEPTH(DEPTH), .NREAD(NREAD)) bus ();
    reg_file_param_if #(.W(W), .DEPTH(12), .NREAD(3))        bus2 ();

    reg_file_param #(.W(W), .DEPTH(DEPTH), .NREAD(NREAD)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    reg_file_param #(.W(W), .DEPTH(12), .NREAD(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    logic [W-1:0]       mem_m [DEPTH];
    logic [DEPTH-1:0]   busy_m;
    logic [NREAD*W-1:0] exp_d;
    logic [NREAD-1:0]   exp_hz;
    logic               exp_vld;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic bit zr(input int a);
        return ZR && (a == 0);
    endfunction

    // Reference: outputs reflect the inputs seen at the edge and the state before it.
    task automatic model();
        int a, rd, bs;
        exp_d = '0; exp_hz = '0; exp_vld = 1'b0;
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) mem_m[r] = '0;
            busy_m = '0;
            return;
        end
        rd = int'(bus.Rd);
        bs = int'(bus.bsy_Rd);
        exp_vld = bus.reg_rd;
        for (int i = 0; i < NREAD; i++) begin
            a = int'(bus.Rs[i*AW +: AW]);
            if (bus.reg_rd && a < DEPTH && !zr(a)) begin
                exp_d[i*W +: W] = (bus.reg_wr && rd == a) ? bus.DI : mem_m[a];
                exp_hz[i] = busy_m[a] && !(bus.reg_wr && rd == a);
            end
        end
        if (bus.reg_wr && rd < DEPTH && !zr(rd)) mem_m[rd] = bus.DI;
        if (bus.reg_wr && rd < DEPTH) busy_m[rd] = 1'b0;
        if (bus.bsy_set && bs < DEPTH && !zr(bs)) busy_m[bs] = 1'b1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".D"},        bus.D,        exp_d);
        chk({tag, ".rd_valid"}, bus.rd_valid, exp_vld);
        chk({tag, ".hazard"},   bus.hazard,   exp_hz);
        chk({tag, ".busy"},     bus.busy,     busy_m);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model();
        #1;
        check_all(tag);
    endtask

    task automatic drv(input bit wr, input int rd, input logic [W-1:0] di, input bit re,
                       input int rs0, input int rs1, input bit bs, input int bsr);
        bus.reg_wr  = wr;
        bus.Rd      = 4'(rd);
        bus.DI      = di;
        bus.reg_rd  = re;
        bus.Rs      = {4'(rs1), 4'(rs0)};
        bus.bsy_set = bs;
        bus.bsy_Rd  = 4'(bsr);
    endtask

    initial begin
        for (int r = 0; r < DEPTH; r++) mem_m[r] = '0;
        busy_m = '0;
        drv(0, 0, '0, 0, 0, 0, 0, 0);
        bus2.reg_wr = 1'b0; bus2.Rd = '0; bus2.DI = '0; bus2.reg_rd = 1'b0;
        bus2.Rs = '0; bus2.bsy_set = 1'b0; bus2.bsy_Rd = '0;

        // Reset state
        #12;
        model();
        check_all("reset");
        rst_n = 1'b1;

        // Write then dual read of the same register
        drv(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);     step("wr5");
        drv(0, 0, '0, 1, 5, 5, 0, 0);                step("rd5");
        chk("rd5_both", bus.D, {2{32'hDEAD_BEEF}});
        chk("rd5_valid", bus.rd_valid, 1'b1);
        drv(0, 0, '0, 0, 5, 5, 0, 0);                step("idle");
        chk("idle_D", bus.D, 64'h0);
        chk("idle_valid", bus.rd_valid, 1'b0);

        // Write-first bypass
        drv(1, 3, 32'h1234, 1, 3, 5, 0, 0);          step("bypass");
        chk("bypass_D0", bus.D[31:0], 32'h1234);
        chk("bypass_hz0", bus.hazard[0], 1'b0);

        // Scoreboard
        drv(0, 0, '0, 0, 0, 0, 1, 7);                step("bset7");
        chk("bset7_busy", bus.busy, 16'h0080);
        drv(0, 0, '0, 1, 7, 2, 0, 0);                step("rd7");
        chk("rd7_hz0", bus.hazard, 2'b01);
        drv(1, 7, 32'h77, 0, 0, 0, 1, 7);            step("wrset7");
        chk("wrset7_busy", bus.busy[7], 1'b1);
        drv(1, 7, 32'h78, 0, 0, 0, 0, 0);            step("wr7");
        chk("wr7_busy", bus.busy, 16'h0);

        // Register 0 behavior
        drv(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0);     step("wr0");
        drv(0, 0, '0, 1, 0, 0, 0, 0);                step("rd0");
`ifdef ZERO_REG_EN
        chk("rd0_D", bus.D, 64'h0);
        chk("rd0_busy0", bus.busy[0], 1'b0);
        chk("rd0_hz", bus.hazard, 2'b00);
`else
        chk("rd0_D", bus.D, {2{32'hFFFF_FFFF}});
        chk("rd0_busy0", bus.busy[0], 1'b1);
        chk("rd0_hz", bus.hazard, 2'b11);
`endif

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            drv(($urandom_range(0, 1) == 1), int'($urandom_range(0, 15)), $urandom,
                ($urandom_range(0, 9) < 7), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)), ($urandom_range(0, 9) < 3),
                int'($urandom_range(0, 15)));
            step("rand");
        end

        // Reset asserted mid-operation
        drv(1, 9, 32'h99, 1, 9, 4, 1, 4);            step("pre_rst");
        drv(1, 2, 32'h22, 1, 2, 4, 1, 6);
        #3 rst_n = 1'b0;
        #1;
        model();
        check_all("rst_async");
        step("rst_hold");
        step("rst_hold");
        rst_n = 1'b1;
        for (int a = 0; a < DEPTH; a += 2) begin
            drv(0, 0, '0, 1, a, a + 1, 0, 0);        step("post_rst");
            chk("post_rst_D", bus.D, 64'h0);
        end

        // Non-power-of-two depth, three ports, out-of-range address
        drv(0, 0, '0, 0, 0, 0, 0, 0);
        bus2.reg_wr = 1'b1; bus2.Rd = 4'd11; bus2.DI = 32'hAAAA;
        bus2.bsy_set = 1'b1; bus2.bsy_Rd = 4'd11;
        step("d12_wr11");
        bus2.reg_wr = 1'b1; bus2.Rd = 4'd13; bus2.DI = 32'h5555;
        bus2.bsy_set = 1'b1; bus2.bsy_Rd = 4'd13;
        bus2.reg_rd = 1'b1; bus2.Rs = {4'd13, 4'd13, 4'd11};
        step("d12_oor");
        chk("d12_D", bus2.D, {32'h0, 32'h0, 32'hAAAA});
        chk("d12_busy", bus2.busy, 12'h800);
        chk("d12_hz", bus2.hazard, 3'b001);
        chk("d12_valid", bus2.rd_valid, 1'b1);
        bus2.reg_wr = 1'b0; bus2.bsy_set = 1'b0;
        bus2.Rs = {4'd11, 4'd13, 4'd13};
        step("d12_rd13");
        chk("d12_rd13_D", bus2.D, {32'hAAAA, 32'h0, 32'h0});
        chk("d12_rd13_busy", bus2.busy, 12'h800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
